// File: rtl/systolic_mm_ctrl.sv
// systolic_mm_ctrl: sequencer for an N x N output-stationary systolic array.
// Clears the PE accumulators, streams K operand reads with a per-lane
// diagonal skew, drives the array-wide PE enable through feed and drain,
// then reads result rows out under a valid/ready handshake.
// Optional build macro: PERF_CNT_EN adds perf_cycles / perf_stall counters.
//
// Result handshake: a row transfers on a cycle where res_valid and
// res_ready are both high. res_valid stays high and res_row holds until
// that transfer; res_valid never depends combinationally on res_ready.
module systolic_mm_ctrl #(
  parameter int N  = 4,
  parameter int KW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [KW-1:0]        k_len,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 acc_clear,
  output logic                 pe_enable,
  output logic                 rd_en,
  output logic [KW-1:0]        rd_addr,
  output logic [N-1:0]         lane_valid,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [$clog2(N)-1:0] res_row,
`ifdef PERF_CNT_EN
  output logic [31:0]          perf_cycles,
  output logic [15:0]          perf_stall,
`endif
  output logic [2:0]           dbg_state
);

  localparam int RW = $clog2(N);
  // Step counter must hold K+2N-2 for the largest K.
  localparam int TW = ($clog2((1 << KW) + 2*N) > KW + 1) ?
                      $clog2((1 << KW) + 2*N) : KW + 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_RUN     = 3'd2,
    S_READOUT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          state, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [TW-1:0]   t_q, t_d;
  logic [RW-1:0]   row_q, row_d;
  logic            err_q, err_d;
  logic            accept;
  logic [TW-1:0]   t_last;

  // Final RUN step: the last product reaches PE(N-1,N-1) here.
  assign t_last    = TW'(k_q) + TW'(2*N - 2);
  assign dbg_state = state;

  // State, latched K, step counter, readout row and error pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      k_q   <= '0;
      t_q   <= '0;
      row_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_d;
      k_q   <= k_d;
      t_q   <= t_d;
      row_q <= row_d;
      err_q <= err_d;
    end
  end

  // Next-state logic; abort from any busy state overrides every transition.
  always_comb begin
    state_d = state;
    k_d     = k_q;
    t_d     = t_q;
    row_d   = row_q;
    err_d   = 1'b0;
    accept  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (k_len != '0) begin
            k_d     = k_len;
            accept  = 1'b1;
            state_d = S_CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        t_d     = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (t_q == t_last) begin
          t_d     = '0;
          row_d   = '0;
          state_d = S_READOUT;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      S_READOUT: begin
        if (res_ready) begin
          if (row_q == RW'(N - 1)) begin
            row_d   = '0;
            state_d = S_DONE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort && (state != S_IDLE)) begin
      state_d = S_IDLE;
      t_d     = '0;
      row_d   = '0;
    end
  end

  // Strobes decoded from the current state and step counter only.
  always_comb begin
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    err        = err_q;
    acc_clear  = (state == S_CLEAR);
    rd_en      = (state == S_RUN) && (t_q < TW'(k_q));
    rd_addr    = rd_en ? t_q[KW-1:0] : '0;
    pe_enable  = (state == S_RUN) && (t_q != '0);
    res_valid  = (state == S_READOUT);
    res_row    = row_q;
    lane_valid = '0;
    for (int i = 0; i < N; i++) begin
      lane_valid[i] = (state == S_RUN) && (t_q >= TW'(1 + i)) &&
                      (t_q <= TW'(k_q) + TW'(i));
    end
  end

`ifdef PERF_CNT_EN
  // Saturating busy-cycle and readout-stall counters, cleared on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (accept) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (busy && (perf_cycles != '1)) perf_cycles <= perf_cycles + 1'b1;
      if ((state == S_READOUT) && !res_ready && (perf_stall != '1))
        perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_mm_ctrl.sv
// tb_systolic_mm_ctrl: randomized jobs against a phase-level reference
// model. Each driven cycle pushes the expected output bundle for that cycle
// into exp_q; a negedge monitor pops and compares.
module tb_systolic_mm_ctrl;
  localparam int N  = 4;
  localparam int KW = 8;
  localparam int RW = $clog2(N);
  localparam int W  = 7 + KW + N + RW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [KW-1:0] k_len;
  logic          abort;
  logic          busy, done, err, acc_clear, pe_enable, rd_en;
  logic [KW-1:0] rd_addr;
  logic [N-1:0]  lane_valid;
  logic          res_valid;
  logic          res_ready;
  logic [RW-1:0] res_row;
  logic [2:0]    dbg_state;
`ifdef PERF_CNT_EN
  logic [31:0]   perf_cycles;
  logic [15:0]   perf_stall;
`endif

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int model_busy;
  int model_stall;

  systolic_mm_ctrl #(.N(N), .KW(KW)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .abort(abort),
    .busy(busy), .done(done), .err(err), .acc_clear(acc_clear),
    .pe_enable(pe_enable), .rd_en(rd_en), .rd_addr(rd_addr),
    .lane_valid(lane_valid), .res_valid(res_valid), .res_ready(res_ready),
    .res_row(res_row),
`ifdef PERF_CNT_EN
    .perf_cycles(perf_cycles), .perf_stall(perf_stall),
`endif
    .dbg_state(dbg_state)
  );

  // Clock: 10 ns period, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic b, input logic d,
      input logic e, input logic c, input logic pe, input logic rd,
      input logic [KW-1:0] addr, input logic [N-1:0] lane,
      input logic rv, input logic [RW-1:0] row);
    return {b, d, e, c, pe, rd, addr, lane, rv, row};
  endfunction

  function automatic logic [W-1:0] cur_vec();
    return {busy, done, err, acc_clear, pe_enable, rd_en, rd_addr,
            lane_valid, res_valid, res_row};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp_v);
    end
  endtask

  // Apply inputs for one cycle, record the expected outputs, advance.
  task automatic drive(input logic st, input logic [KW-1:0] kl,
                       input logic ab, input logic rr, input logic [W-1:0] e);
    start     = st;
    k_len     = kl;
    abort     = ab;
    res_ready = rr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One multiply job from the start cycle onward.
  // stall_row/stall_len: hold res_ready low before that row transfers.
  // abort_t: RUN step at which abort is raised (-1 none).
  // inject_t: RUN step at which a stray start with k_len=5 is raised.
  // rst_row: stop driving when readout reaches this row (-1 none).
  task automatic job(input int k, input int stall_row, input int stall_len,
                     input int abort_t, input int inject_t, input int rst_row);
    int last;
    logic [N-1:0] lane;
    last = k + 2*N - 2;
    model_busy  = 0;
    model_stall = 0;
    // Start cycle: still IDLE; abort here must not block acceptance.
    drive(1'b1, KW'(k), rbit(), rbit(), '0);
    // Accumulator clear; a start with any k_len here is ignored.
    drive(rbit(), KW'($urandom_range(0, 3)), 1'b0, rbit(),
          mk(1, 0, 0, 1, 0, 0, '0, '0, 0, '0));
    model_busy++;
    for (int t = 0; t <= last; t++) begin
      for (int i = 0; i < N; i++) lane[i] = (t >= 1 + i) && (t <= k + i);
      drive(t == inject_t, (t == inject_t) ? KW'(5) : KW'($urandom),
            t == abort_t, rbit(),
            mk(1, 0, 0, 0, t >= 1, t < k, (t < k) ? KW'(t) : KW'(0),
               lane, 0, '0));
      model_busy++;
      if (t == abort_t) return;
    end
    for (int r = 0; r < N; r++) begin
      if (r == rst_row) return;
      if (r == stall_row) begin
        for (int s = 0; s < stall_len; s++) begin
          drive(1'($urandom_range(0, 3) == 0), KW'($urandom), 1'b0, 1'b0,
                mk(1, 0, 0, 0, 0, 0, '0, '0, 1, RW'(r)));
          model_busy++;
          model_stall++;
        end
      end
      drive(1'($urandom_range(0, 3) == 0), KW'($urandom), 1'b0, 1'b1,
            mk(1, 0, 0, 0, 0, 0, '0, '0, 1, RW'(r)));
      model_busy++;
    end
    drive(1'b0, KW'($urandom), 1'b0, rbit(),
          mk(1, 1, 0, 0, 0, 0, '0, '0, 0, '0));
    model_busy++;
  endtask

  task automatic perf_chk();
`ifdef PERF_CNT_EN
    chk("perf_cycles", 64'(perf_cycles), 64'(model_busy));
    chk("perf_stall", 64'(perf_stall), 64'(model_stall));
`endif
  endtask

  // Start with k_len==0: one-cycle err pulse in the next cycle, no activity.
  task automatic err_job();
    drive(1'b1, '0, rbit(), rbit(), '0);
    drive(1'b0, KW'($urandom), 1'b0, rbit(),
          mk(0, 0, 1, 0, 0, 0, '0, '0, 0, '0));
  endtask

  // Monitor: compare every cycle for which an expectation was queued.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("outputs", 64'(cur_vec()), 64'(e));
      end
    end
  end

  // Watchdog: the stimulus never waits on the DUT, this is a backstop only.
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Driver: directed scenarios, random jobs, async reset, summary.
  initial begin
    int k, sr, sl, at, it;
    rst = 1'b1; start = 1'b0; k_len = '0; abort = 1'b0; res_ready = 1'b0;
    #12;
    chk("reset_outputs", 64'(cur_vec()), 64'(0));
`ifdef PERF_CNT_EN
    chk("reset_perf", 64'({perf_cycles, perf_stall}), 64'(0));
`endif
    #10 rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic K=8 run, res_ready high throughout readout.
    job(8, -1, 0, -1, -1, -1);
    perf_chk();
    // Three-cycle stall on row 1.
    job(8, 1, 3, -1, -1, -1);
    perf_chk();
    // Zero-length request.
    err_job();
    // Stray start during RUN is ignored.
    job(8, -1, 0, -1, 4, -1);
    perf_chk();
    // Abort at RUN step 6, then a new job accepted right after.
    job(8, -1, 0, 6, -1, -1);
    perf_chk();
    job(3, 2, 2, -1, -1, -1);
    perf_chk();
    // Shortest and longest K.
    job(1, 0, 1, -1, -1, -1);
    perf_chk();
    job(255, N - 1, 2, -1, 100, -1);
    perf_chk();

    // Randomized jobs.
    for (int n = 0; n < 16; n++) begin
      k  = $urandom_range(1, 20);
      sr = $urandom_range(0, N);
      sr = (sr == N) ? -1 : sr;
      sl = $urandom_range(1, 4);
      at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, k + 2*N - 2) : -1;
      it = $urandom_range(0, k + 2*N - 2);
      if ($urandom_range(0, 4) == 0) err_job();
      job(k, sr, sl, at, it, -1);
      perf_chk();
    end

    // Asynchronous reset while reading out row 2.
    job(8, -1, 0, -1, -1, 2);
    #2;
    chk("pre_rst_readout", 64'({busy, res_valid, res_row}),
        64'({1'b1, 1'b1, RW'(2)}));
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", 64'(cur_vec()), 64'(0));
`ifdef PERF_CNT_EN
    chk("async_rst_perf", 64'({perf_cycles, perf_stall}), 64'(0));
`endif
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    job(1, -1, 0, -1, -1, -1);
    perf_chk();

    // Trailing idle cycles.
    for (int n = 0; n < 3; n++) drive(1'b0, KW'($urandom), rbit(), rbit(), '0);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d queued expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
